// File: rtl/alu_ops_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forwarding selects
// and the iterative multiplier's state.
package alu_ops_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_RD      = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUOUTM = 2'b10,
    FWD_RD_ALT  = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/execute_stage_if.sv
// D/E-register inputs and E/M-register outputs of the execute stage,
// plus the stall line back to the hazard unit.
interface execute_stage_if #(
  parameter int DATA_W = 32
);
  logic              RegWriteE, MemtoRegE, MemWriteE, BranchE, AluSrcE, RegDstE;
  logic [2:0]        AluControlE;
  logic [DATA_W-1:0] RD1E, RD2E;
  logic [4:0]        RtE, RdE;
  logic [DATA_W-1:0] SignImmE, PCPlus4E;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [DATA_W-1:0] ResultW;

  logic              StallE;
  logic              RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
  logic [DATA_W-1:0] AluOutM, WriteDataM, PCBranchM;
  logic [4:0]        WriteRegM;

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, BranchE, AluSrcE, RegDstE,
    output AluControlE, RD1E, RD2E, RtE, RdE, SignImmE, PCPlus4E,
    output ForwardAE, ForwardBE, ResultW,
    input  StallE, RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM,
    input  AluOutM, WriteDataM, PCBranchM, WriteRegM
  );

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, BranchE, AluSrcE, RegDstE,
    input  AluControlE, RD1E, RD2E, RtE, RdE, SignImmE, PCPlus4E,
    input  ForwardAE, ForwardBE, ResultW,
    output StallE, RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM,
    output AluOutM, WriteDataM, PCBranchM, WriteRegM
  );
endinterface

// File: rtl/iter_multiplier.sv
// 32-step shift-add multiplier (low word only). Operands are latched on
// start, so live forwarding can keep changing while the product is built.
module iter_multiplier
  import alu_ops_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_pulse_o,
  output logic [DATA_W-1:0] product_o
);

  mul_state_t        state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = DONE;
      end
      DONE: state_d = IDLE;  // never re-arms here; a new MUL starts from IDLE
      default: state_d = IDLE;
    endcase
  end

  // Start is combinational so the stall covers the issue cycle itself.
  assign busy_o       = (state_q == BUSY) || ((state_q == IDLE) && start_i);
  assign done_pulse_o = (state_q == DONE);
  assign product_o    = acc_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: operand forwarding, ALU, write-register select,
// branch target adder, iterative MUL and the E/M pipeline register.
module execute_stage
  import alu_ops_pkg::*;
#(
  parameter int         DATA_W = DATA_W_DEF,
  parameter logic [2:0] MUL_OP = ALU_MUL
) (
  input logic            clk,
  input logic            reset,
  execute_stage_if.slave e_if
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              zero;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_branch;
    logic [4:0]        write_reg;
  } em_t;

  em_t               em_q, em_d;
  logic [DATA_W-1:0] src_a, src_b, write_data, alu_res, mul_product;
  logic              mul_start, mul_busy, mul_done, slt_bit;

  function automatic logic [DATA_W-1:0] fwd_pick(fwd_sel_t sel, logic [DATA_W-1:0] rd,
                                                 logic [DATA_W-1:0] res_w,
                                                 logic [DATA_W-1:0] alu_m);
    case (sel)
      FWD_RESULTW: return res_w;
      FWD_ALUOUTM: return alu_m;
      default:     return rd;
    endcase
  endfunction

  assign src_a      = fwd_pick(fwd_sel_t'(e_if.ForwardAE), e_if.RD1E, e_if.ResultW, em_q.alu_out);
  assign write_data = fwd_pick(fwd_sel_t'(e_if.ForwardBE), e_if.RD2E, e_if.ResultW, em_q.alu_out);
  assign src_b      = e_if.AluSrcE ? e_if.SignImmE : write_data;
  assign slt_bit    = $signed(src_a) < $signed(src_b);
  assign mul_start  = (e_if.AluControlE == MUL_OP);

  iter_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start_i      (mul_start),
    .a_i          (src_a),
    .b_i          (src_b),
    .busy_o       (mul_busy),
    .done_pulse_o (mul_done),
    .product_o    (mul_product)
  );

  always_comb begin
    alu_res = '0;
    if (e_if.AluControlE == MUL_OP) begin
      alu_res = mul_done ? mul_product : '0;
    end else begin
      case (e_if.AluControlE)
        ALU_AND: alu_res = src_a & src_b;
        ALU_OR:  alu_res = src_a | src_b;
        ALU_ADD: alu_res = src_a + src_b;
        ALU_SUB: alu_res = src_a - src_b;
        ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
        default: alu_res = '0;
      endcase
    end
  end

  // While the multiplier is busy the M side sees a fully zeroed bubble.
  always_comb begin
    em_d = '0;
    if (!mul_busy) begin
      em_d.reg_write  = e_if.RegWriteE;
      em_d.mem_to_reg = e_if.MemtoRegE;
      em_d.mem_write  = e_if.MemWriteE;
      em_d.branch     = e_if.BranchE;
      em_d.zero       = (alu_res == '0);
      em_d.alu_out    = alu_res;
      em_d.write_data = write_data;
      em_d.pc_branch  = e_if.PCPlus4E + (e_if.SignImmE << 2);
      em_d.write_reg  = e_if.RegDstE ? e_if.RdE : e_if.RtE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) em_q <= '0;
    else       em_q <= em_d;
  end

  assign e_if.StallE     = mul_busy;
  assign e_if.RegWriteM  = em_q.reg_write;
  assign e_if.MemtoRegM  = em_q.mem_to_reg;
  assign e_if.MemWriteM  = em_q.mem_write;
  assign e_if.BranchM    = em_q.branch;
  assign e_if.ZeroM      = em_q.zero;
  assign e_if.AluOutM    = em_q.alu_out;
  assign e_if.WriteDataM = em_q.write_data;
  assign e_if.PCBranchM  = em_q.pc_branch;
  assign e_if.WriteRegM  = em_q.write_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against an arithmetic
// reference model of forwarding, ALU, branch target and MUL timing.
module tb_execute_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_stage_if #(.DATA_W(32)) eif();

  execute_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .e_if  (eif)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_txn    = 0;
  logic [31:0] m_alu    = 32'd0;  // model of AluOutM, used for forwarding
  logic [2:0]  single_ops [7] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_fwd(logic [1:0] s, logic [31:0] rd, logic [31:0] res_w);
    if (s == 2'b01) return res_w;
    if (s == 2'b10) return m_alu;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic nop_inputs();
    {eif.RegWriteE, eif.MemtoRegE, eif.MemWriteE, eif.BranchE, eif.AluSrcE, eif.RegDstE} = 6'd0;
    eif.AluControlE = 3'b000;
    eif.RD1E = 0; eif.RD2E = 0; eif.RtE = 0; eif.RdE = 0;
    eif.SignImmE = 0; eif.PCPlus4E = 0;
    eif.ForwardAE = 0; eif.ForwardBE = 0; eif.ResultW = 0;
  endtask

  task automatic rand_inputs();
    eif.RegWriteE   = 1'($urandom_range(0, 1));
    eif.MemtoRegE   = 1'($urandom_range(0, 1));
    eif.MemWriteE   = 1'($urandom_range(0, 1));
    eif.BranchE     = 1'($urandom_range(0, 1));
    eif.AluSrcE     = 1'($urandom_range(0, 1));
    eif.RegDstE     = 1'($urandom_range(0, 1));
    eif.AluControlE = single_ops[$urandom_range(0, 6)];
    eif.RD1E        = $urandom;
    eif.RD2E        = ($urandom_range(0, 3) == 0) ? eif.RD1E : $urandom;
    eif.RtE         = 5'($urandom_range(0, 31));
    eif.RdE         = 5'($urandom_range(0, 31));
    eif.SignImmE    = $urandom;
    eif.PCPlus4E    = $urandom;
    eif.ForwardAE   = 2'($urandom_range(0, 3));
    eif.ForwardBE   = 2'($urandom_range(0, 3));
    eif.ResultW     = $urandom;
  endtask

  task automatic check_m_zero(string tag);
    chk({tag, "_ctl"},  {28'd0, eif.RegWriteM, eif.MemtoRegM, eif.MemWriteM, eif.BranchM}, 32'd0);
    chk({tag, "_alu"},  eif.AluOutM, 32'd0);
    chk({tag, "_zero"}, 32'(eif.ZeroM), 32'd0);
    chk({tag, "_wreg"}, 32'(eif.WriteRegM), 32'd0);
    chk({tag, "_pcb"},  eif.PCBranchM, 32'd0);
    chk({tag, "_wd"},   eif.WriteDataM, 32'd0);
  endtask

  // Issues the instruction currently on the inputs (called just after an edge)
  // and checks the E/M register once the instruction has left E.
  task automatic step(string tag);
    logic [31:0] a, wd, b, res, pcb;
    logic [3:0]  ctl;
    logic [4:0]  wreg;
    logic        is_mul;
    is_mul = (eif.AluControlE == 3'b011);
    a    = ref_fwd(eif.ForwardAE, eif.RD1E, eif.ResultW);
    wd   = ref_fwd(eif.ForwardBE, eif.RD2E, eif.ResultW);
    b    = eif.AluSrcE ? eif.SignImmE : wd;
    res  = ref_alu(eif.AluControlE, a, b);
    pcb  = eif.PCPlus4E + eif.SignImmE * 32'd4;
    wreg = eif.RegDstE ? eif.RdE : eif.RtE;
    ctl  = {eif.RegWriteE, eif.MemtoRegE, eif.MemWriteE, eif.BranchE};
    if (is_mul) begin
      for (int k = 0; k < 33; k++) begin
        @(negedge clk);
        chk({tag, "_stall_hi"}, 32'(eif.StallE), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_bub_ctl"}, {28'd0, eif.RegWriteM, eif.MemtoRegM, eif.MemWriteM, eif.BranchM}, 32'd0);
        chk({tag, "_bub_alu"}, eif.AluOutM, 32'd0);
        m_alu = 32'd0;
        eif.ResultW = $urandom;  // W keeps draining; must not leak into the product
      end
    end
    @(negedge clk);
    chk({tag, "_stall_lo"}, 32'(eif.StallE), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_alu"},  eif.AluOutM, res);
    chk({tag, "_zero"}, 32'(eif.ZeroM), 32'(res == 32'd0));
    chk({tag, "_wreg"}, 32'(eif.WriteRegM), 32'(wreg));
    chk({tag, "_pcb"},  eif.PCBranchM, pcb);
    chk({tag, "_ctl"},  {28'd0, eif.RegWriteM, eif.MemtoRegM, eif.MemWriteM, eif.BranchM}, {28'd0, ctl});
    if (!is_mul) chk({tag, "_wd"}, eif.WriteDataM, wd);
    m_alu = res;
    n_txn++;
    $display("txn %0d %s op=%0d a=%h b=%h alu=%h", n_txn, tag, a == a ? 0 : 0, a, b, res);
  endtask

  initial begin
    reset = 1'b1;
    nop_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(eif.StallE), 32'd0);
    check_m_zero("rst");
    reset = 1'b0;
    m_alu = 32'd0;

    // Reset in the middle of a multiply aborts it.
    nop_inputs();
    eif.AluControlE = 3'b011; eif.RegWriteE = 1'b1; eif.RD1E = 32'd3; eif.RD2E = 32'd5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rstmul_stall_hi", 32'(eif.StallE), 32'd1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    nop_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    m_alu = 32'd0;
    chk("rstmul_stall_lo", 32'(eif.StallE), 32'd0);
    check_m_zero("rstmul");
    for (int k = 0; k < 23; k++) step("rstmul_nop");

    rand_inputs(); eif.AluControlE = 3'b010; eif.RD1E = 7; eif.RD2E = 5;
    eif.ForwardAE = 0; eif.ForwardBE = 0; eif.AluSrcE = 0;
    step("add");
    chk("add_val", eif.AluOutM, 32'd12);

    rand_inputs(); eif.AluControlE = 3'b110; eif.RD1E = 5; eif.RD2E = 5;
    eif.ForwardAE = 0; eif.ForwardBE = 0; eif.AluSrcE = 0;
    step("sub");
    chk("sub_zero", 32'(eif.ZeroM), 32'd1);

    rand_inputs(); eif.AluControlE = 3'b111; eif.RD1E = 32'hFFFF_FFFF; eif.RD2E = 1;
    eif.ForwardAE = 0; eif.ForwardBE = 0; eif.AluSrcE = 0;
    step("slt");
    chk("slt_val", eif.AluOutM, 32'd1);

    rand_inputs(); eif.SignImmE = 32'hFFFF_FFFF; eif.PCPlus4E = 32'h100;
    step("pcb");
    chk("pcb_val", eif.PCBranchM, 32'h0000_00FC);

    rand_inputs(); eif.RegDstE = 1; eif.RdE = 9; eif.RtE = 4;
    step("regdst1");
    chk("regdst1_val", 32'(eif.WriteRegM), 32'd9);
    rand_inputs(); eif.RegDstE = 0; eif.RdE = 9; eif.RtE = 4;
    step("regdst0");
    chk("regdst0_val", 32'(eif.WriteRegM), 32'd4);

    rand_inputs(); eif.AluControlE = 3'b010; eif.RD1E = 32'h10; eif.RD2E = 32'h10;
    eif.ForwardAE = 0; eif.ForwardBE = 0; eif.AluSrcE = 0;
    step("fwd_prep");
    rand_inputs(); eif.AluControlE = 3'b010; eif.ForwardAE = 2'b10; eif.RD1E = 0;
    eif.ForwardBE = 0; eif.AluSrcE = 0; eif.RD2E = 32'h5;
    step("fwd_a_m");
    chk("fwd_a_m_val", eif.AluOutM, 32'h25);

    rand_inputs(); eif.ForwardBE = 2'b01; eif.MemWriteE = 1; eif.ResultW = 32'hCAFE_0001;
    step("fwd_b_w");
    chk("fwd_b_w_val", eif.WriteDataM, 32'hCAFE_0001);

    rand_inputs(); eif.AluControlE = 3'b001; eif.AluSrcE = 1; eif.ForwardBE = 2'b01;
    step("alusrc");

    rand_inputs(); eif.AluControlE = 3'b011; eif.RD1E = 32'h0001_0003; eif.RD2E = 32'h10;
    eif.ForwardAE = 0; eif.ForwardBE = 0; eif.AluSrcE = 0; eif.RegWriteE = 1;
    step("mul_a");
    chk("mul_a_val", eif.AluOutM, 32'h0010_0030);

    rand_inputs(); eif.AluControlE = 3'b011; eif.RD1E = 32'hFFFF_FFFF; eif.RD2E = 32'hFFFF_FFFF;
    eif.ForwardAE = 0; eif.ForwardBE = 0; eif.AluSrcE = 0;
    step("mul_ff");
    chk("mul_ff_val", eif.AluOutM, 32'd1);

    rand_inputs(); eif.AluControlE = 3'b011; eif.ForwardAE = 2'b01; eif.ResultW = 32'd1234;
    eif.ForwardBE = 0; eif.AluSrcE = 0; eif.RD2E = 32'd3;
    step("mul_fwd");
    chk("mul_fwd_val", eif.AluOutM, 32'd3702);

    rand_inputs(); eif.AluControlE = 3'b011;
    step("mul_b2b_1");
    rand_inputs(); eif.AluControlE = 3'b011;
    step("mul_b2b_2");

    rand_inputs(); eif.AluControlE = 3'b100;
    step("op100");
    chk("op100_zero", 32'(eif.ZeroM), 32'd1);

    for (int i = 0; i < 150; i++) begin
      rand_inputs();
      if ($urandom_range(0, 7) == 0) eif.AluControlE = 3'b011;
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
